wakeup_issue_queue: RTL and testbench
=====================================

WAKEUP_ISSUE_QUEUE -- requirements
Module: wakeup_issue_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction payload width.
REQ-002 SHALL have parameter DEPTH, default 16, entry count (power of two, 4..64).
REQ-003 SHALL have parameter TAG_WIDTH, default 6, physical-register tag width.
REQ-004 SHALL have parameter WAKE_PORTS, default 2, number of wakeup broadcast ports.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port enq_valid, input, 1, enqueue request.
REQ-008 SHALL have port enq_ready, output, 1, slot available (= !full).
REQ-009 SHALL have port enq_data, input, DATA_WIDTH, instruction payload.
REQ-010 SHALL have ports enq_src1_tag/enq_src2_tag, input, TAG_WIDTH each, source tags.
REQ-011 SHALL have ports enq_src1_rdy/enq_src2_rdy, input, 1 each, source already available.
REQ-012 SHALL have port enq_dst_tag, input, TAG_WIDTH, destination tag.
REQ-013 SHALL have port wake_valid, input, WAKE_PORTS, per-port broadcast valid.
REQ-014 SHALL have port wake_tag, input, WAKE_PORTS*TAG_WIDTH, broadcast tags (port i at [i*TAG_WIDTH +: TAG_WIDTH]).
REQ-015 SHALL have port iss_valid, output, 1, a ready entry is presented.
REQ-016 SHALL have port iss_ready, input, 1, execution unit accepts.
REQ-017 SHALL have ports iss_data (DATA_WIDTH) and iss_dst_tag (TAG_WIDTH), output, issued entry.
REQ-018 SHALL have port flush, input, 1, synchronous discard of all entries.
REQ-019 SHALL have ports full, empty (1 each) and count ($clog2(DEPTH+1)), output, occupancy.

Function
REQ-020 Entry state: valid, payload, src1/src2 tag+ready, dst tag, age row.
REQ-021 Enqueue on enq_valid&enq_ready writes lowest-index invalid slot at clock edge.
REQ-022 Wakeup: any wake port i with wake_valid[i] whose tag equals a valid entry's unready source tag sets that ready bit at next edge; all ports compared in parallel.
REQ-023 Issue select combinational: iss_valid=1 iff any valid entry has both sources ready; selected entry is the OLDEST such entry per age matrix.
REQ-024 iss_data/iss_dst_tag SHALL be 0 when iss_valid=0.
REQ-025 Handshake iss_valid&iss_ready invalidates the selected entry at the edge; latency enqueue-with-ready-sources to iss_valid = 1 cycle.
REQ-026 Simultaneous enqueue and issue: count unchanged; freed slot not reusable same cycle; enq_ready depends only on registered full.
REQ-027 Full (count==DEPTH): enq_ready=0, enq_valid ignored; empty (count==0): iss_valid=0.
REQ-028 flush has priority over enqueue, issue and wakeup: all entries invalid, count=0 next cycle.
REQ-029 Age matrix: on enqueue, new entry marked younger than every valid entry; row/column cleared on issue.

Reset
REQ-030 resetn low asynchronously clears all valid bits, ready bits, age matrix and count; outputs: enq_ready=1, iss_valid=0, full=0, empty=1, count=0, iss_data=0, iss_dst_tag=0.
REQ-031 Reset asserted mid-handshake discards the in-flight enqueue/issue; no entry survives.

Configuration
REQ-032 Macro WAKEUP_ISSUE_QUEUE_ENQ_BYPASS_EN defined: enqueued source tag matching a same-cycle wakeup is stored ready.
REQ-033 Macro undefined: enqueued sources store enq_srcN_rdy unmodified; upstream guarantees no same-cycle overlap.

Structure
REQ-034 Shared package iq_pkg SHALL hold iq_entry_t typedef and tag-width constant.
REQ-035 Sub-module iq_age_matrix SHALL implement age tracking and oldest-of-request-vector select.

Verification
REQ-036 Enqueue data 0x11 src rdy=1/1, iss_ready=1 -> iss_valid next cycle, iss_data=0x11, count 1->0.
REQ-037 Enqueue A(src1 tag 5 unready), then B(ready); wake tag 5 -> B issues first, A next cycle after wakeup.
REQ-038 Fill 16 entries -> full=1, enq_ready=0, 17th enq_valid ignored, count=16.
REQ-039 Two ready entries enqueued order C then D, iss_ready=1 -> C then D regardless of slot index.
REQ-040 With bypass macro: enqueue src2 tag 9 unready while wake tag 9 valid -> entry issuable next cycle.
REQ-041 flush with 5 entries and concurrent enq_valid -> count=0, empty=1, iss_valid=0 next cycle.

Source files
------------

// File: rtl/iq_pkg.sv
// Shared definitions for the wakeup issue queue.
//   IQ_TAG_WIDTH : default physical-register tag width
//   iq_entry_t   : per-slot status flags (valid + two source ready bits);
//                  payload and tags live in parameter-width arrays next to it
package iq_pkg;

  localparam int IQ_TAG_WIDTH = 6;

  typedef struct packed {
    logic valid;
    logic src1_rdy;
    logic src2_rdy;
  } iq_entry_t;

endpackage

// File: rtl/iq_age_matrix.sv
// Age tracking for the issue queue plus oldest-of-request select.
// older_r[i][j] = 1 means slot i was enqueued before slot j (both valid).
// Ports:
//   clk, resetn     : clock, asynchronous active-low reset
//   flush           : synchronous clear of all age relations
//   enq_en/enq_sel  : enqueue strobe and one-hot target slot
//   valid           : current slot valid vector (before this edge)
//   iss_en/iss_sel  : issue strobe and one-hot issued slot
//   req             : request vector (ready entries)
//   gnt             : one-hot grant of the oldest requester (0 if none)
module iq_age_matrix
  import iq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             enq_en,
  input  logic [DEPTH-1:0] enq_sel,
  input  logic [DEPTH-1:0] valid,
  input  logic             iss_en,
  input  logic [DEPTH-1:0] iss_sel,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] gnt
);

  logic [DEPTH-1:0] older_r [DEPTH];
  logic [DEPTH-1:0] blocked_s;

  // Age relation update: new entry is younger than every valid entry,
  // issued entry drops out of both its row and column.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) older_r[i] <= {DEPTH{1'b0}};
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) older_r[i] <= {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (iss_en && (iss_sel[i] || iss_sel[j])) begin
            older_r[i][j] <= 1'b0;
          end else if (enq_en && enq_sel[j]) begin
            // Target slot is free, so valid[j] is 0 and the diagonal stays 0.
            older_r[i][j] <= valid[i];
          end else if (enq_en && enq_sel[i]) begin
            older_r[i][j] <= 1'b0;
          end else begin
            older_r[i][j] <= older_r[i][j];
          end
        end
      end
    end
  end

  // Oldest select: a requester wins when no other requester is older.
  always_comb begin
    blocked_s = {DEPTH{1'b0}};
    gnt       = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        blocked_s[i] = blocked_s[i] | (req[j] & older_r[j][i]);
      end
      gnt[i] = req[i] & ~blocked_s[i];
    end
  end

endmodule

// File: rtl/wakeup_issue_queue.sv
// Out-of-order issue queue with tag-broadcast wakeup and oldest-first select.
// Optional feature macro: WAKEUP_ISSUE_QUEUE_ENQ_BYPASS_EN -- when defined, an
// enqueued source whose tag matches a same-cycle wakeup is stored ready.
// Ports:
//   clk, resetn                  : clock, asynchronous active-low reset
//   enq_valid/enq_ready          : enqueue handshake (enq_ready = !full)
//   enq_data, enq_src*_tag/_rdy,
//   enq_dst_tag                  : enqueued instruction
//   wake_valid, wake_tag         : WAKE_PORTS tag broadcasts
//   iss_valid/iss_ready          : issue handshake
//   iss_data, iss_dst_tag        : selected entry (0 when iss_valid = 0)
//   flush                        : synchronous discard of all entries
//   full, empty, count           : occupancy
module wakeup_issue_queue
  import iq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int TAG_WIDTH  = IQ_TAG_WIDTH,
  parameter int WAKE_PORTS = 2
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            enq_valid,
  output logic                            enq_ready,
  input  logic [DATA_WIDTH-1:0]           enq_data,
  input  logic [TAG_WIDTH-1:0]            enq_src1_tag,
  input  logic [TAG_WIDTH-1:0]            enq_src2_tag,
  input  logic                            enq_src1_rdy,
  input  logic                            enq_src2_rdy,
  input  logic [TAG_WIDTH-1:0]            enq_dst_tag,
  input  logic [WAKE_PORTS-1:0]           wake_valid,
  input  logic [WAKE_PORTS*TAG_WIDTH-1:0] wake_tag,
  output logic                            iss_valid,
  input  logic                            iss_ready,
  output logic [DATA_WIDTH-1:0]           iss_data,
  output logic [TAG_WIDTH-1:0]            iss_dst_tag,
  input  logic                            flush,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(DEPTH+1)-1:0]      count
);

  localparam int CW = $clog2(DEPTH+1);

  iq_entry_t             ent_r      [DEPTH];
  logic [DATA_WIDTH-1:0] data_r     [DEPTH];
  logic [TAG_WIDTH-1:0]  src1_tag_r [DEPTH];
  logic [TAG_WIDTH-1:0]  src2_tag_r [DEPTH];
  logic [TAG_WIDTH-1:0]  dst_tag_r  [DEPTH];
  logic [CW-1:0]         count_r;

  logic [DEPTH-1:0] valid_s;
  logic [DEPTH-1:0] req_s;
  logic [DEPTH-1:0] gnt_s;
  logic [DEPTH-1:0] enq_sel_s;
  logic             found_s;
  logic             enq_fire_s;
  logic             iss_fire_s;
  logic             enq_src1_rdy_s;
  logic             enq_src2_rdy_s;

  // True when any valid broadcast port carries the given tag.
  function automatic logic wake_hit(input logic [WAKE_PORTS-1:0]           v,
                                    input logic [WAKE_PORTS*TAG_WIDTH-1:0] tags,
                                    input logic [TAG_WIDTH-1:0]            tag);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WAKE_PORTS; p++) begin
      hit = hit | (v[p] & (tags[p*TAG_WIDTH +: TAG_WIDTH] == tag));
    end
    return hit;
  endfunction

  assign full       = (count_r == CW'(DEPTH));
  assign empty      = (count_r == {CW{1'b0}});
  assign count      = count_r;
  assign enq_ready  = ~full;
  assign enq_fire_s = enq_valid & enq_ready;
  assign iss_valid  = |req_s;
  assign iss_fire_s = iss_valid & iss_ready;

  // Per-slot valid and ready-to-issue vectors; lowest free slot for enqueue.
  always_comb begin
    valid_s   = {DEPTH{1'b0}};
    req_s     = {DEPTH{1'b0}};
    enq_sel_s = {DEPTH{1'b0}};
    found_s   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_s[i]   = ent_r[i].valid;
      req_s[i]     = ent_r[i].valid & ent_r[i].src1_rdy & ent_r[i].src2_rdy;
      enq_sel_s[i] = ~ent_r[i].valid & ~found_s;
      found_s      = found_s | ~ent_r[i].valid;
    end
  end

  // Source ready bits captured at enqueue.
  always_comb begin
`ifdef WAKEUP_ISSUE_QUEUE_ENQ_BYPASS_EN
    enq_src1_rdy_s = enq_src1_rdy | wake_hit(wake_valid, wake_tag, enq_src1_tag);
    enq_src2_rdy_s = enq_src2_rdy | wake_hit(wake_valid, wake_tag, enq_src2_tag);
`else
    enq_src1_rdy_s = enq_src1_rdy;
    enq_src2_rdy_s = enq_src2_rdy;
`endif
  end

  // Issue mux: one-hot grant AND-OR, so outputs are zero with no grant.
  always_comb begin
    iss_data    = {DATA_WIDTH{1'b0}};
    iss_dst_tag = {TAG_WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      iss_data    = iss_data    | (data_r[i]    & {DATA_WIDTH{gnt_s[i]}});
      iss_dst_tag = iss_dst_tag | (dst_tag_r[i] & {TAG_WIDTH{gnt_s[i]}});
    end
  end

  // Entry storage: flush beats enqueue, issue and wakeup.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i]      <= '{valid: 1'b0, src1_rdy: 1'b0, src2_rdy: 1'b0};
        data_r[i]     <= {DATA_WIDTH{1'b0}};
        src1_tag_r[i] <= {TAG_WIDTH{1'b0}};
        src2_tag_r[i] <= {TAG_WIDTH{1'b0}};
        dst_tag_r[i]  <= {TAG_WIDTH{1'b0}};
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i] <= '{valid: 1'b0, src1_rdy: 1'b0, src2_rdy: 1'b0};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (enq_fire_s && enq_sel_s[i]) begin
          ent_r[i]      <= '{valid: 1'b1, src1_rdy: enq_src1_rdy_s, src2_rdy: enq_src2_rdy_s};
          data_r[i]     <= enq_data;
          src1_tag_r[i] <= enq_src1_tag;
          src2_tag_r[i] <= enq_src2_tag;
          dst_tag_r[i]  <= enq_dst_tag;
        end else if (iss_fire_s && gnt_s[i]) begin
          ent_r[i] <= '{valid: 1'b0, src1_rdy: 1'b0, src2_rdy: 1'b0};
        end else begin
          ent_r[i].src1_rdy <= ent_r[i].src1_rdy |
                               (ent_r[i].valid & wake_hit(wake_valid, wake_tag, src1_tag_r[i]));
          ent_r[i].src2_rdy <= ent_r[i].src2_rdy |
                               (ent_r[i].valid & wake_hit(wake_valid, wake_tag, src2_tag_r[i]));
        end
      end
    end
  end

  // Occupancy counter; simultaneous enqueue and issue leave it unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_r <= {CW{1'b0}};
    end else if (flush) begin
      count_r <= {CW{1'b0}};
    end else begin
      case ({enq_fire_s, iss_fire_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  iq_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk     (clk),
    .resetn  (resetn),
    .flush   (flush),
    .enq_en  (enq_fire_s),
    .enq_sel (enq_sel_s),
    .valid   (valid_s),
    .iss_en  (iss_fire_s),
    .iss_sel (gnt_s),
    .req     (req_s),
    .gnt     (gnt_s)
  );

endmodule

// File: tb/tb_wakeup_issue_queue.sv
// Directed bench for wakeup_issue_queue. Expected issue order is pushed to a
// scoreboard queue when stimulus is driven and popped on every handshake.
module tb_wakeup_issue_queue;

  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int TW = 6;
  localparam int WP = 2;
  localparam int CW = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          resetn;
  logic          enq_valid, enq_ready;
  logic [DW-1:0] enq_data;
  logic [TW-1:0] enq_src1_tag, enq_src2_tag, enq_dst_tag;
  logic          enq_src1_rdy, enq_src2_rdy;
  logic [WP-1:0] wake_valid;
  logic [WP*TW-1:0] wake_tag;
  logic          iss_valid, iss_ready;
  logic [DW-1:0] iss_data;
  logic [TW-1:0] iss_dst_tag;
  logic          flush, full, empty;
  logic [CW-1:0] count;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] dst;
  } exp_t;

  exp_t sb[$];
  int n_total = 0;
  int n_pass  = 0;

  wakeup_issue_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TAG_WIDTH(TW), .WAKE_PORTS(WP)) dut (
    .clk(clk), .resetn(resetn),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
    .enq_src1_tag(enq_src1_tag), .enq_src2_tag(enq_src2_tag),
    .enq_src1_rdy(enq_src1_rdy), .enq_src2_rdy(enq_src2_rdy),
    .enq_dst_tag(enq_dst_tag),
    .wake_valid(wake_valid), .wake_tag(wake_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_data(iss_data), .iss_dst_tag(iss_dst_tag),
    .flush(flush), .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: compare any handshake against the scoreboard, then advance.
  task automatic cycle();
    exp_t e;
    #1;
    if (iss_valid === 1'b1 && iss_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_issue", {31'd0, iss_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("iss_data", iss_data, e.data);
        chk("iss_dst_tag", {26'd0, iss_dst_tag}, {26'd0, e.dst});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input logic [DW-1:0] d, input logic [TW-1:0] t1, input logic r1,
                         input logic [TW-1:0] t2, input logic r2, input logic [TW-1:0] dst);
    enq_valid = 1'b1; enq_data = d;
    enq_src1_tag = t1; enq_src1_rdy = r1;
    enq_src2_tag = t2; enq_src2_rdy = r2;
    enq_dst_tag = dst;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [TW-1:0] dst);
    exp_t e;
    e.data = d;
    e.dst  = dst;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    iss_ready = 1'b1;
    for (int k = 0; k < budget && sb.size() != 0; k++) cycle();
    chk("drain_left", sb.size(), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; enq_valid = 1'b0; enq_data = '0;
    enq_src1_tag = '0; enq_src2_tag = '0; enq_dst_tag = '0;
    enq_src1_rdy = 1'b0; enq_src2_rdy = 1'b0;
    wake_valid = '0; wake_tag = '0; iss_ready = 1'b0; flush = 1'b0;

    // Reset values
    #2;
    chk("rst_enq_ready", {31'd0, enq_ready}, 32'd1);
    chk("rst_iss_valid", {31'd0, iss_valid}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_iss_data", iss_data, 32'd0);
    chk("rst_iss_dst", {26'd0, iss_dst_tag}, 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Single ready entry: visible one cycle after enqueue
    iss_ready = 1'b1;
    set_enq(32'h11, 6'd1, 1'b1, 6'd2, 1'b1, 6'd3);
    push(32'h11, 6'd3);
    cycle();
    enq_valid = 1'b0;
    #1;
    chk("lat_iss_valid", {31'd0, iss_valid}, 32'd1);
    chk("lat_count1", {27'd0, count}, 32'd1);
    cycle();
    chk("lat_count0", {27'd0, count}, 32'd0);
    chk("lat_empty", {31'd0, empty}, 32'd1);
    chk("idle_iss_valid", {31'd0, iss_valid}, 32'd0);
    chk("idle_iss_data", iss_data, 32'd0);

    // A waits on tag 5; B (ready) goes first; wake 5 on port 1 releases A
    set_enq(32'hA, 6'd5, 1'b0, 6'd1, 1'b1, 6'd10);
    cycle();
    chk("a_blocked", {31'd0, iss_valid}, 32'd0);
    set_enq(32'hB, 6'd2, 1'b1, 6'd3, 1'b1, 6'd11);
    wake_valid = 2'b10; wake_tag = {6'd7, 6'd0};
    push(32'hB, 6'd11);
    cycle();
    enq_valid = 1'b0;
    wake_valid = 2'b10; wake_tag = {6'd5, 6'd0};
    push(32'hA, 6'd10);
    cycle();
    wake_valid = 2'b00;
    cycle();
    chk("wake_empty", {31'd0, empty}, 32'd1);

    // Fill to capacity; the extra request is ignored
    iss_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_enq(32'h100 + i, 6'd0, 1'b1, 6'd0, 1'b1, TW'(i));
      push(32'h100 + i, TW'(i));
      cycle();
    end
    enq_valid = 1'b0;
    chk("full_flag", {31'd0, full}, 32'd1);
    chk("full_enq_ready", {31'd0, enq_ready}, 32'd0);
    chk("full_count", {27'd0, count}, 32'd16);
    set_enq(32'h999, 6'd0, 1'b1, 6'd0, 1'b1, 6'd63);
    cycle();
    enq_valid = 1'b0;
    chk("full_count_after_extra", {27'd0, count}, 32'd16);
    drain(40);
    chk("drain_empty", {31'd0, empty}, 32'd1);

    // Age beats slot index: D lands in slot 0 below older C in slot 1
    iss_ready = 1'b0;
    set_enq(32'h61, 6'd0, 1'b1, 6'd0, 1'b1, 6'd1); push(32'h61, 6'd1); cycle();
    set_enq(32'h62, 6'd0, 1'b1, 6'd0, 1'b1, 6'd2); push(32'h62, 6'd2); cycle();
    enq_valid = 1'b0; iss_ready = 1'b1;
    cycle();
    iss_ready = 1'b0;
    set_enq(32'h63, 6'd0, 1'b1, 6'd0, 1'b1, 6'd3); push(32'h63, 6'd3); cycle();
    // Enqueue E while C issues: occupancy stays at 2
    set_enq(32'h64, 6'd0, 1'b1, 6'd0, 1'b1, 6'd4); push(32'h64, 6'd4);
    iss_ready = 1'b1;
    cycle();
    enq_valid = 1'b0;
    chk("enq_iss_count", {27'd0, count}, 32'd2);
    drain(10);

    // Flush with 5 entries and a concurrent enqueue
    iss_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_enq(32'h200 + i, 6'd0, 1'b1, 6'd0, 1'b1, 6'd0);
      cycle();
    end
    enq_valid = 1'b0;
    chk("pre_flush_count", {27'd0, count}, 32'd5);
    flush = 1'b1;
    set_enq(32'h77, 6'd0, 1'b1, 6'd0, 1'b1, 6'd0);
    cycle();
    flush = 1'b0; enq_valid = 1'b0;
    chk("flush_count", {27'd0, count}, 32'd0);
    chk("flush_empty", {31'd0, empty}, 32'd1);
    chk("flush_iss_valid", {31'd0, iss_valid}, 32'd0);
    chk("flush_enq_ready", {31'd0, enq_ready}, 32'd1);
    iss_ready = 1'b1;
    cycle();
    chk("post_flush_iss_valid", {31'd0, iss_valid}, 32'd0);

    // Reset in the middle of an enqueue/issue handshake
    iss_ready = 1'b0;
    set_enq(32'h301, 6'd0, 1'b1, 6'd0, 1'b1, 6'd0); cycle();
    set_enq(32'h302, 6'd0, 1'b1, 6'd0, 1'b1, 6'd0); cycle();
    set_enq(32'h303, 6'd0, 1'b1, 6'd0, 1'b1, 6'd0);
    iss_ready = 1'b1;
    #3 resetn = 1'b0;
    #1;
    chk("midrst_count", {27'd0, count}, 32'd0);
    chk("midrst_iss_valid", {31'd0, iss_valid}, 32'd0);
    enq_valid = 1'b0; iss_ready = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    cycle();
    chk("post_rst_empty", {31'd0, empty}, 32'd1);

`ifdef WAKEUP_ISSUE_QUEUE_ENQ_BYPASS_EN
    // Source woken in the enqueue cycle is stored ready
    iss_ready = 1'b0;
    set_enq(32'h9A, 6'd1, 1'b1, 6'd9, 1'b0, 6'd4);
    wake_valid = 2'b01; wake_tag = {6'd0, 6'd9};
    cycle();
    enq_valid = 1'b0; wake_valid = 2'b00;
    chk("bypass_iss_valid", {31'd0, iss_valid}, 32'd1);
    push(32'h9A, 6'd4);
    drain(5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
